led_breath_ctrl: RTL and testbench

LED driver stage that replaces the free-running counter-bit LED output on the Nano 9K with a mode-selectable PWM driver. The debounced on-board button selects the mode: OFF, BLINK, or BREATH (triangular brightness ramp). The block drives the board LED pin directly from the 27 MHz clock domain and is the last stage before the pad.

---
 rtl/led_pkg.sv | 26 ++
 rtl/btn_debounce.sv | 67 ++++++
 rtl/led_breath_ctrl.sv | 140 ++++++++++++++
 tb/tb_led_breath_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared encodings for the LED breath/blink driver.
package led_pkg;

    localparam int unsigned CLK_HZ = 27_000_000;

    localparam logic [1:0] MODE_OFF    = 2'd0;
    localparam logic [1:0] MODE_BLINK  = 2'd1;
    localparam logic [1:0] MODE_BREATH = 2'd2;

    typedef enum logic [1:0] {
        BR_UP      = 2'd0,
        BR_HOLD_HI = 2'd1,
        BR_DOWN    = 2'd2,
        BR_HOLD_LO = 2'd3
    } breath_state_e;

    // Mode rotation OFF -> BLINK -> BREATH -> OFF; never yields 3.
    function automatic logic [1:0] next_mode(input logic [1:0] m);
        case (m)
            MODE_OFF:   return MODE_BLINK;
            MODE_BLINK: return MODE_BREATH;
            default:    return MODE_OFF;
        endcase
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button synchronizer and debouncer; emits a one-cycle pulse on each accepted press.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 270000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n,
    output logic level,
    output logic press
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic             armed_q, armed_d;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            armed_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_n;
            sync2_q <= sync1_q;
            level_q <= level_d;
            armed_q <= armed_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    // Until a stable release has been seen after reset, a button held through
    // reset must not count as a press: only released samples are counted.
    always_comb begin
        level_d = level_q;
        armed_d = armed_q;
        press_d = 1'b0;
        cnt_d   = '0;
        if (!armed_q) begin
            if (sync2_q) begin
                if (cnt_q == CNT_LAST) begin
                    armed_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end else if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
                press_d = level_q & ~sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/led_breath_ctrl.sv
// Mode-selectable LED PWM driver (OFF / BLINK / BREATH) for the board LED pin.
module led_breath_ctrl
    import led_pkg::*;
#(
    parameter int unsigned PWM_BITS        = 8,
    parameter int unsigned STEP_CYCLES     = 26367,
    parameter int unsigned HOLD_STEPS      = 64,
    parameter int unsigned DEBOUNCE_CYCLES = 270000,
    parameter int unsigned LED_ACTIVE_LOW  = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                btn_n,
    output logic                led,
    output logic [1:0]          mode,
    output logic [PWM_BITS-1:0] duty
);

    localparam int unsigned STEP_W  = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam int unsigned HOLD_W  = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;
    localparam int unsigned BLINK_W = 8;

    localparam logic [STEP_W-1:0]   STEP_LAST = STEP_W'(STEP_CYCLES - 1);
    localparam logic [HOLD_W-1:0]   HOLD_LAST = HOLD_W'(HOLD_STEPS - 1);
    localparam logic [PWM_BITS-1:0] DUTY_MAX  = '1;
    localparam logic                LED_OFF   = (LED_ACTIVE_LOW != 0);

    logic                btn_level;
    logic                btn_press;
    logic                mode_adv_c;
    logic                step_c;

    logic [1:0]          mode_q, mode_d;
    breath_state_e       state_q, state_d;
    logic [PWM_BITS-1:0] duty_q, duty_d;
    logic [PWM_BITS-1:0] pwm_q, pwm_d;
    logic [STEP_W-1:0]   timer_q, timer_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [BLINK_W-1:0]  blink_q, blink_d;
    logic                led_q, led_d;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
        .clk   (clk),
        .rst_n (rst_n),
        .btn_n (btn_n),
        .level (btn_level),
        .press (btn_press)
    );

    // A press pulse is only valid while the debounced level reads pressed.
    assign mode_adv_c = btn_press & ~btn_level;
    assign step_c     = (timer_q == STEP_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q  <= MODE_BREATH;
            state_q <= BR_HOLD_LO;
            duty_q  <= '0;
            pwm_q   <= '0;
            timer_q <= '0;
            hold_q  <= '0;
            blink_q <= '0;
            led_q   <= LED_OFF;
        end else begin
            mode_q  <= mode_d;
            state_q <= state_d;
            duty_q  <= duty_d;
            pwm_q   <= pwm_d;
            timer_q <= timer_d;
            hold_q  <= hold_d;
            blink_q <= blink_d;
            led_q   <= led_d;
        end
    end

    // Mode change clears the brightness pattern and takes priority over a step.
    always_comb begin
        mode_d  = mode_q;
        state_d = state_q;
        duty_d  = duty_q;
        hold_d  = hold_q;
        blink_d = blink_q;
        timer_d = step_c ? '0 : timer_q + STEP_W'(1);
        pwm_d   = pwm_q + PWM_BITS'(1);
        led_d   = (pwm_q < duty_q) ? ~LED_OFF : LED_OFF;

        if (mode_adv_c) begin
            mode_d  = next_mode(mode_q);
            state_d = BR_HOLD_LO;
            duty_d  = '0;
            hold_d  = '0;
            blink_d = '0;
            timer_d = '0;
        end else if (step_c) begin
            case (mode_q)
                MODE_BLINK: begin
                    blink_d = blink_q + BLINK_W'(1);
                    duty_d  = blink_d[BLINK_W-1] ? DUTY_MAX : '0;
                end
                MODE_BREATH: begin
                    case (state_q)
                        BR_UP: begin
                            if (duty_q == DUTY_MAX) begin
                                state_d = BR_HOLD_HI;
                                hold_d  = '0;
                            end else begin
                                duty_d = duty_q + PWM_BITS'(1);
                            end
                        end
                        BR_HOLD_HI: begin
                            if (hold_q == HOLD_LAST) state_d = BR_DOWN;
                            else                     hold_d  = hold_q + HOLD_W'(1);
                        end
                        BR_DOWN: begin
                            if (duty_q == '0) begin
                                state_d = BR_HOLD_LO;
                                hold_d  = '0;
                            end else begin
                                duty_d = duty_q - PWM_BITS'(1);
                            end
                        end
                        BR_HOLD_LO: begin
                            if (hold_q == HOLD_LAST) state_d = BR_UP;
                            else                     hold_d  = hold_q + HOLD_W'(1);
                        end
                        default: state_d = BR_HOLD_LO;
                    endcase
                end
                default: duty_d = '0;
            endcase
        end
    end

    assign led  = led_q;
    assign mode = mode_q;
    assign duty = duty_q;

endmodule

// File: tb/tb_led_breath_ctrl.sv
// Scoreboard bench for led_breath_ctrl with a step-count based reference model.
module tb_led_breath_ctrl;

    localparam int STEP_CYCLES = 4;
    localparam int HOLD_STEPS  = 2;
    localparam int DEB         = 8;
    localparam int PERIOD      = 2 * HOLD_STEPS + 512;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       btn_n = 1'b1;
    logic       led;
    logic [1:0] mode;
    logic [7:0] duty;

    typedef struct packed {
        logic       led;
        logic [1:0] mode;
        logic [7:0] duty;
    } obs_t;

    obs_t exp_q[$];
    int   press_edges[$];
    int   checks   = 0;
    int   errors   = 0;
    int   ecnt     = 0;
    int   m_mode   = 2;
    int   m_c      = 0;
    int   m_pwm    = 0;
    int   clr_edge = 0;
    int   max_duty = 0;

    always #5 clk = ~clk;

    led_breath_ctrl #(
        .PWM_BITS        (8),
        .STEP_CYCLES     (STEP_CYCLES),
        .HOLD_STEPS      (HOLD_STEPS),
        .DEBOUNCE_CYCLES (DEB),
        .LED_ACTIVE_LOW  (1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .btn_n (btn_n),
        .led   (led),
        .mode  (mode),
        .duty  (duty)
    );

    // Brightness after k steps since entering the low hold, one period:
    // hold 0, ramp 1..255, 255 for the turn step plus the hold, ramp 254..0, turn step.
    function automatic int breath_duty(input int k);
        int j;
        if (k == 0) return 0;
        j = ((k - 1) % PERIOD) + 1;
        if (j <= HOLD_STEPS)           return 0;
        if (j <= HOLD_STEPS + 255)     return j - HOLD_STEPS;
        if (j <= 2 * HOLD_STEPS + 256) return 255;
        if (j <= 2 * HOLD_STEPS + 511) return 255 - (j - (2 * HOLD_STEPS + 256));
        return 0;
    endfunction

    function automatic int model_duty(input int md, input int c);
        int k;
        k = c / STEP_CYCLES;
        if (md == 2) return breath_duty(k);
        if (md == 1) return ((k % 256) >= 128) ? 255 : 0;
        return 0;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d cycle=%0d", name, act, exp, ecnt);
        end
    endtask

    // Reference model: predicts the outputs seen after each rising edge.
    always @(posedge clk or negedge rst_n) begin : model
        obs_t e;
        if (!rst_n) begin
            ecnt     = 0;
            m_mode   = 2;
            m_c      = 0;
            m_pwm    = 0;
            clr_edge = 0;
            exp_q.delete();
            press_edges.delete();
        end else begin
            e.led = (m_pwm < model_duty(m_mode, m_c)) ? 1'b0 : 1'b1;
            ecnt  = ecnt + 1;
            m_pwm = (m_pwm + 1) % 256;
            if (press_edges.size() != 0 && press_edges[0] == ecnt) begin
                void'(press_edges.pop_front());
                m_mode   = (m_mode + 1) % 3;
                m_c      = 0;
                clr_edge = ecnt;
            end else begin
                m_c = m_c + 1;
            end
            e.mode = 2'(m_mode);
            e.duty = 8'(model_duty(m_mode, m_c));
            exp_q.push_back(e);
        end
    end

    always @(negedge clk) begin : monitor
        obs_t e;
        if (rst_n && ecnt > 0) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_empty actual=none expected=entry cycle=%0d", ecnt);
            end else begin
                e = exp_q.pop_front();
                check("sb_led",  int'(led),  int'(e.led));
                check("sb_mode", int'(mode), int'(e.mode));
                check("sb_duty", int'(duty), int'(e.duty));
                if (int'(duty) > max_duty) max_duty = int'(duty);
            end
        end
    end

    task automatic wait_edge(input int target);
        while (ecnt < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Low pulse of 'low' cycles, then 'high' released cycles; schedules the expected mode change.
    task automatic drive_pulse(input int low, input int high);
        @(posedge clk);
        #1;
        if (low >= DEB) press_edges.push_back(ecnt + DEB + 3);
        btn_n = 1'b0;
        repeat (low) @(posedge clk);
        #1 btn_n = 1'b1;
        repeat (high) @(posedge clk);
    endtask

    task automatic count_lit(output int n);
        n = 0;
        repeat (256) begin
            @(negedge clk);
            if (led == 1'b0) n++;
        end
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog actual=timeout expected=finish cycle=%0d", ecnt);
        $fatal(1);
    end

    initial begin : stim
        int lit;
        int n;
        int tgt;
        int lo;
        int hi;

        #2 rst_n = 1'b0;
        #1;
        check("rst_led",  int'(led),  1);
        check("rst_mode", int'(mode), 2);
        check("rst_duty", int'(duty), 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;

        repeat (PERIOD * STEP_CYCLES + 40) @(posedge clk);
        check("breath_peak", max_duty, 255);

        drive_pulse(5, 20);
        drive_pulse(20, 20);
        count_lit(lit);
        check("off_lit", lit, 0);

        drive_pulse(DEB + 3, DEB + 6);
        wait_edge(clr_edge + 520);
        count_lit(lit);
        check("blink_full_lit", lit, 255);

        drive_pulse(DEB + 3, DEB + 6);
        // Press lands on the step edge that would raise duty 100 -> 101.
        tgt = clr_edge + 412;
        n   = tgt - (DEB + 3);
        wait_edge(n);
        btn_n = 1'b0;
        press_edges.push_back(n + DEB + 3);
        wait_edge(tgt);
        @(negedge clk);
        check("coinc_mode", int'(mode), 0);
        check("coinc_duty", int'(duty), 0);
        @(posedge clk);
        #1 btn_n = 1'b1;
        repeat (DEB + 6) @(posedge clk);

        drive_pulse(DEB - 1, DEB + 3);
        drive_pulse(DEB, DEB + 3);
        repeat (14) begin
            lo = int'($urandom_range(1, 2 * DEB + 4));
            hi = int'($urandom_range(DEB + 3, 40));
            drive_pulse(lo, hi);
        end

        while (m_mode != 2) drive_pulse(DEB + 2, DEB + 6);
        wait_edge(clr_edge + 300);

        @(posedge clk);
        #2;
        btn_n = 1'b0;
        rst_n = 1'b0;
        #1;
        check("async_led",  int'(led),  1);
        check("async_duty", int'(duty), 0);
        check("async_mode", int'(mode), 2);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1 btn_n = 1'b1;
        repeat (DEB + 6) @(posedge clk);
        @(negedge clk);
        check("held_reset_mode", int'(mode), 2);
        drive_pulse(DEB + 4, DEB + 6);
        @(negedge clk);
        check("after_held_mode", int'(mode), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
